// File: rtl/battle_pkg.sv
// Shared constants, state encoding and sizing helper for battle_front_scan.
// Empty-slot type code, tower locations (friendly all-ones, enemy zero) and scan states.
package battle_pkg;

    localparam int TYPE_EMPTY = 0;

    // Tower locations; consumers slice the low LOC_W bits.
    localparam logic [63:0] TOWER_F_LOC = {64{1'b1}};
    localparam logic [63:0] TOWER_E_LOC = {64{1'b0}};

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SCAN   = 2'd1,
        ADJUST = 2'd2,
        DONE   = 2'd3
    } scanState_t;

    function automatic int idxWidth(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/battle_front_scan_slot_select.sv
// slot_select: combinational {loc, type} slice of one slot chosen by index.
// Ports: locVec/typeVec packed slot vectors, idx slot index, loc/typ selected fields.
module slot_select #(
    parameter int N_SLOTS = 16,
    parameter int LOC_W   = 9,
    parameter int TYPE_W  = 2,
    parameter int IDX_W   = 4
) (
    input  logic [N_SLOTS*LOC_W-1:0]  locVec,
    input  logic [N_SLOTS*TYPE_W-1:0] typeVec,
    input  logic [IDX_W-1:0]          idx,
    output logic [LOC_W-1:0]          loc,
    output logic [TYPE_W-1:0]         typ
);

    // Loop mux keeps out-of-range indices harmless when N_SLOTS is not a power of two.
    always_comb begin
        loc = '0;
        typ = '0;
        for (int k = 0; k < N_SLOTS; k++) begin
            if (idx == IDX_W'(k)) begin
                loc = locVec[k*LOC_W +: LOC_W];
                typ = typeVec[k*TYPE_W +: TYPE_W];
            end
        end
    end

endmodule

// File: rtl/battle_front_scan.sv
// battle_front_scan: sequential scan of friendly/enemy slots for the fronts.
// Ports: clk, rst (sync, active-high), start/ack handshake, unit_*/enemy_* slot
// vectors in; adjusted fronts, selected slots (MSB=tower), live counts,
// busy/done/engaged out. Optional: BATTLE_FRONT_ENGAGE_EN enables engaged.
module battle_front_scan
    import battle_pkg::*;
#(
    parameter int N_SLOTS  = 16,
    parameter int LOC_W    = 9,
    parameter int TYPE_W   = 2,
    parameter int F_OFFSET = 6,
    parameter int E_OFFSET = 7,
    localparam int IDX_W   = idxWidth(N_SLOTS)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic                      ack,
    input  logic [N_SLOTS*LOC_W-1:0]  unit_loc,
    input  logic [N_SLOTS*LOC_W-1:0]  enemy_loc,
    input  logic [N_SLOTS*TYPE_W-1:0] unit_type,
    input  logic [N_SLOTS*TYPE_W-1:0] enemy_type,
    output logic [LOC_W-1:0]          friendly_front,
    output logic [LOC_W-1:0]          enemy_front,
    output logic [IDX_W:0]            unit_sel,
    output logic [IDX_W:0]            enemy_sel,
    output logic [IDX_W:0]            unit_count,
    output logic [IDX_W:0]            enemy_count,
    output logic                      busy,
    output logic                      done,
    output logic                      engaged
);

    localparam logic [LOC_W-1:0] LOC_MAX   = '1;
    localparam logic [LOC_W:0]   F_OFF     = (LOC_W+1)'(F_OFFSET);
    localparam logic [LOC_W:0]   E_OFF     = (LOC_W+1)'(E_OFFSET);
    localparam logic [IDX_W:0]   SEL_TOWER = {1'b1, {IDX_W{1'b0}}};
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(N_SLOTS - 1);
    localparam logic [IDX_W-1:0] SCAN_IDX0 = IDX_W'((N_SLOTS > 1) ? 1 : 0);

    scanState_t state;
    scanState_t nextState;

    logic [IDX_W-1:0]  idx;
    logic [IDX_W-1:0]  selIdx;
    logic              adjPhase;
    logic [LOC_W-1:0]  uLoc;
    logic [LOC_W-1:0]  eLoc;
    logic [TYPE_W-1:0] uTyp;
    logic [TYPE_W-1:0] eTyp;
    logic              uLive;
    logic              eLive;
    logic              fUnder;
    logic [LOC_W:0]    fSub;
    logic [LOC_W:0]    eSum;

    // Slot 0 is loaded while still in IDLE.
    assign selIdx = (state == IDLE) ? '0 : idx;

    slot_select #(
        .N_SLOTS(N_SLOTS),
        .LOC_W  (LOC_W),
        .TYPE_W (TYPE_W),
        .IDX_W  (IDX_W)
    ) uUnitSel (
        .locVec (unit_loc),
        .typeVec(unit_type),
        .idx    (selIdx),
        .loc    (uLoc),
        .typ    (uTyp)
    );

    slot_select #(
        .N_SLOTS(N_SLOTS),
        .LOC_W  (LOC_W),
        .TYPE_W (TYPE_W),
        .IDX_W  (IDX_W)
    ) uEnemySel (
        .locVec (enemy_loc),
        .typeVec(enemy_type),
        .idx    (selIdx),
        .loc    (eLoc),
        .typ    (eTyp)
    );

    assign uLive  = (uTyp != TYPE_W'(TYPE_EMPTY));
    assign eLive  = (eTyp != TYPE_W'(TYPE_EMPTY));
    assign fUnder = ({1'b0, friendly_front} < F_OFF);
    assign fSub   = {1'b0, friendly_front} - F_OFF;
    assign eSum   = {1'b0, enemy_front} + E_OFF;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // ADJUST takes two cycles: saturate fronts, then settle engaged from
    // the adjusted values. Both builds keep it so latency never changes.
    always_comb begin
        nextState = state;
        unique case (state)
            IDLE: begin
                if (start) begin
                    nextState = (N_SLOTS == 1) ? ADJUST : SCAN;
                end
            end
            SCAN: begin
                if (idx == LAST_IDX) begin
                    nextState = ADJUST;
                end
            end
            ADJUST: begin
                if (adjPhase) begin
                    nextState = DONE;
                end
            end
            DONE: begin
                if (ack) begin
                    nextState = IDLE;
                end
            end
            default: nextState = IDLE;
        endcase
    end

    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        unique case (state)
            SCAN, ADJUST: busy = 1'b1;
            DONE:         done = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx            <= '0;
            adjPhase       <= 1'b0;
            friendly_front <= '0;
            enemy_front    <= '0;
            unit_sel       <= '0;
            enemy_sel      <= '0;
            unit_count     <= '0;
            enemy_count    <= '0;
`ifdef BATTLE_FRONT_ENGAGE_EN
            engaged        <= 1'b0;
`endif
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        idx            <= SCAN_IDX0;
                        adjPhase       <= 1'b0;
                        friendly_front <= uLive ? uLoc : TOWER_F_LOC[LOC_W-1:0];
                        unit_sel       <= uLive ? '0 : SEL_TOWER;
                        unit_count     <= {{IDX_W{1'b0}}, uLive};
                        enemy_front    <= eLive ? eLoc : TOWER_E_LOC[LOC_W-1:0];
                        enemy_sel      <= eLive ? '0 : SEL_TOWER;
                        enemy_count    <= {{IDX_W{1'b0}}, eLive};
`ifdef BATTLE_FRONT_ENGAGE_EN
                        engaged        <= 1'b0;
`endif
                    end
                end
                SCAN: begin
                    idx <= (idx == LAST_IDX) ? '0 : idx + 1'b1;
                    // Strict compares: on ties the earlier slot is kept.
                    if (uLive) begin
                        unit_count <= unit_count + 1'b1;
                        if (uLoc < friendly_front) begin
                            friendly_front <= uLoc;
                            unit_sel       <= {1'b0, idx};
                        end
                    end
                    if (eLive) begin
                        enemy_count <= enemy_count + 1'b1;
                        if (eLoc > enemy_front) begin
                            enemy_front <= eLoc;
                            enemy_sel   <= {1'b0, idx};
                        end
                    end
                end
                ADJUST: begin
                    if (!adjPhase) begin
                        adjPhase       <= 1'b1;
                        friendly_front <= fUnder ? '0 : fSub[LOC_W-1:0];
                        enemy_front    <= eSum[LOC_W] ? LOC_MAX : eSum[LOC_W-1:0];
                    end else begin
                        adjPhase <= 1'b0;
`ifdef BATTLE_FRONT_ENGAGE_EN
                        engaged  <= (enemy_front >= friendly_front);
`endif
                    end
                end
                DONE: ;
                default: ;
            endcase
        end
    end

`ifndef BATTLE_FRONT_ENGAGE_EN
    assign engaged = 1'b0;
`endif

endmodule
